sc_chain_programmer: RTL

- Master-side driver for a configuration scan chain built from sc_dff cells.
- Accepts configuration words over a valid/ready stream, serializes them MSB-first into the chain head and counts CHAIN_LEN shift cycles.
- Then runs a non-destructive readback pass. The chain tail is recirculated into the head, and the ones-count read back is compared against the ones-count loaded.
- Sits between the bitstream source and the fabric configuration chain.

---
 rtl/sc_cfg_pkg.sv | 20 ++
 rtl/sc_word_serializer.sv | 46 ++++
 rtl/sc_chain_programmer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sc_cfg_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain programmer.
package sc_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sc_state_e;

    function automatic int words_needed(input int chain_len, input int word_width);
        return (chain_len + word_width - 1) / word_width;
    endfunction

    // Bits of the final word that actually reach the chain; the rest are dropped.
    function automatic int last_word_bits(input int chain_len, input int word_width);
        return chain_len - (words_needed(chain_len, word_width) - 1) * word_width;
    endfunction

endpackage

// File: rtl/sc_word_serializer.sv
// MSB-first word serializer feeding the chain head; accepts a new word while
// the previous one is shifting its last bit so the chain never idles needlessly.
module sc_word_serializer #(
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  more_words,
    input  logic [LEN_WIDTH-1:0]  word_len,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  sc_head,
    output logic                  bit_valid
);
    import sc_cfg_pkg::*;

    logic [WORD_WIDTH-1:0] shift_r;
    logic [LEN_WIDTH-1:0]  remain_r;
    logic                  take_s;

    assign bit_valid  = (remain_r != {LEN_WIDTH{1'b0}});
    assign word_ready = more_words && (remain_r <= LEN_WIDTH'(1));
    assign take_s     = word_ready && word_valid;
    assign sc_head    = shift_r[WORD_WIDTH-1];

    // Shift register and remaining-bit count; a load overrides the final shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r  <= {WORD_WIDTH{1'b0}};
            remain_r <= {LEN_WIDTH{1'b0}};
        end else if (clear) begin
            shift_r  <= {WORD_WIDTH{1'b0}};
            remain_r <= {LEN_WIDTH{1'b0}};
        end else if (take_s) begin
            shift_r  <= word_data;
            remain_r <= word_len;
        end else if (bit_valid) begin
            shift_r  <= {shift_r[WORD_WIDTH-2:0], 1'b0};
            remain_r <= remain_r - LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_chain_programmer.sv
// Loads a configuration scan chain from a word stream, then recirculates it once
// to compare the ones-count read back against the ones-count loaded.
module sc_chain_programmer #(
    parameter int WORD_WIDTH = 8,
    parameter int CHAIN_LEN  = 64,
    parameter int CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  sc_head,
    output logic                  sc_en,
    input  logic                  sc_tail,
    output logic [CNT_WIDTH-1:0]  bit_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import sc_cfg_pkg::*;

    localparam int WORDS     = words_needed(CHAIN_LEN, WORD_WIDTH);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_WIDTH);
    localparam int LEN_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam int WL_WIDTH  = $clog2(WORDS + 1);

    sc_state_e            state_r;
    logic [CNT_WIDTH-1:0] bit_count_r;
    logic [CNT_WIDTH-1:0] load_ones_r;
    logic [CNT_WIDTH-1:0] rb_ones_r;
    logic [WL_WIDTH-1:0]  words_left_r;
    logic                 done_r;
    logic                 error_r;

    logic                 abort_s;
    logic                 go_s;
    logic                 clear_s;
    logic                 more_words_s;
    logic [LEN_WIDTH-1:0] word_len_s;
    logic                 ser_head_s;
    logic                 bit_valid_s;
    logic                 take_s;
    logic                 last_bit_s;
    logic [CNT_WIDTH-1:0] rb_final_s;

    assign abort_s      = abort && (state_r != IDLE);
    assign go_s         = start && ((state_r == IDLE) || (state_r == DONE));
    assign clear_s      = abort_s || go_s;
    assign more_words_s = (state_r == LOAD) && (words_left_r != {WL_WIDTH{1'b0}});
    assign word_len_s   = (words_left_r == WL_WIDTH'(1)) ? LEN_WIDTH'(LAST_BITS)
                                                         : LEN_WIDTH'(WORD_WIDTH);
    assign take_s       = word_ready && word_valid;
    assign last_bit_s   = (bit_count_r == CNT_WIDTH'(CHAIN_LEN - 1));
    assign rb_final_s   = rb_ones_r + CNT_WIDTH'(sc_tail);

    sc_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_s),
        .more_words (more_words_s),
        .word_len   (word_len_s),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .sc_head    (ser_head_s),
        .bit_valid  (bit_valid_s)
    );

    // Chain drive: serializer during load, tail recirculation during verify.
    always_comb begin
        sc_en   = 1'b0;
        sc_head = 1'b0;
        case (state_r)
            LOAD: begin
                sc_en   = bit_valid_s;
                sc_head = ser_head_s;
            end
            VERIFY: begin
                sc_en   = 1'b1;
                sc_head = sc_tail;
            end
            default: begin
                sc_en   = 1'b0;
                sc_head = 1'b0;
            end
        endcase
    end

    assign bit_count = bit_count_r;
    assign busy      = (state_r == LOAD) || (state_r == VERIFY);
    assign done      = done_r;
    assign error     = error_r;

    // Phase sequencing, shift and ones counters; abort outranks everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            bit_count_r  <= {CNT_WIDTH{1'b0}};
            load_ones_r  <= {CNT_WIDTH{1'b0}};
            rb_ones_r    <= {CNT_WIDTH{1'b0}};
            words_left_r <= {WL_WIDTH{1'b0}};
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else if (abort_s) begin
            state_r      <= IDLE;
            bit_count_r  <= {CNT_WIDTH{1'b0}};
            load_ones_r  <= {CNT_WIDTH{1'b0}};
            rb_ones_r    <= {CNT_WIDTH{1'b0}};
            words_left_r <= {WL_WIDTH{1'b0}};
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (go_s) begin
                        state_r      <= LOAD;
                        bit_count_r  <= {CNT_WIDTH{1'b0}};
                        load_ones_r  <= {CNT_WIDTH{1'b0}};
                        rb_ones_r    <= {CNT_WIDTH{1'b0}};
                        words_left_r <= WL_WIDTH'(WORDS);
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (take_s) begin
                        words_left_r <= words_left_r - WL_WIDTH'(1);
                    end
                    if (bit_valid_s) begin
                        load_ones_r <= load_ones_r + CNT_WIDTH'(ser_head_s);
                        if (last_bit_s) begin
                            state_r     <= VERIFY;
                            bit_count_r <= {CNT_WIDTH{1'b0}};
                        end else begin
                            bit_count_r <= bit_count_r + CNT_WIDTH'(1);
                        end
                    end
                end
                VERIFY: begin
                    rb_ones_r   <= rb_final_s;
                    bit_count_r <= bit_count_r + CNT_WIDTH'(1);
                    if (last_bit_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        error_r <= (rb_final_s != load_ones_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
